// File: rtl/vend_credit_sequencer.sv
// Vending sequencer: accumulates coin credit, pulses guffin at price, then
// pays change greedily (halves before quarters) through a req/ack ejector.
module vend_credit_sequencer #(
  parameter int PRICE_Q    = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       quarter_in,
  input  logic       halfDollar_in,
  input  logic       dollar_in,
  input  logic       eject_ack,
  output logic       guffin,
  output logic       quarter_out,
  output logic       halfDollar_out,
  output logic       coin_reject,
  output logic       busy,
  output logic [2:0] credit,
  output logic [2:0] state_code
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [2:0]    PRICE    = 3'(PRICE_Q);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VEND    = 3'd1,
    ST_CHANGE  = 3'd2,
    ST_EJECT_Q = 3'd3,
    ST_EJECT_H = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    credit_q, credit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          coin_reject_q, coin_reject_d;

  logic [2:0] coins_s;
  logic [2:0] coin_val_s;
  logic       multi_s;
  logic [2:0] sum_s;

  // Decode the coin inputs into a value; more than one high at once is refused.
  always_comb begin
    coins_s    = {dollar_in, halfDollar_in, quarter_in};
    coin_val_s = 3'd0;
    multi_s    = 1'b0;
    case (coins_s)
      3'b000:  coin_val_s = 3'd0;
      3'b001:  coin_val_s = 3'd1;
      3'b010:  coin_val_s = 3'd2;
      3'b100:  coin_val_s = 3'd4;
      default: multi_s    = 1'b1;
    endcase
    sum_s = credit_q + coin_val_s;
  end

  // Next-state, credit and gap counter computation.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    gap_d         = gap_q;
    coin_reject_d = (state_q != ST_IDLE) ? (coins_s != 3'b000) : multi_s;
    case (state_q)
      ST_IDLE: begin
        if (!multi_s && (coin_val_s != 3'd0)) begin
          credit_d = sum_s;
          state_d  = (sum_s >= PRICE) ? ST_VEND : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        credit_d = credit_q - PRICE;
        state_d  = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (credit_q >= 3'd2) begin
          state_d = ST_EJECT_H;
        end else if (credit_q == 3'd1) begin
          state_d = ST_EJECT_Q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EJECT_Q, ST_EJECT_H: begin
        if (eject_ack) begin
          credit_d = credit_q - ((state_q == ST_EJECT_H) ? 3'd2 : 3'd1);
          gap_d    = GAP_INIT;
          state_d  = (GAP_CYCLES == 0) ? ST_CHANGE : ST_GAP;
        end else begin
          state_d = state_q;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_ONE) begin
          gap_d   = '0;
          state_d = ST_CHANGE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 3'd0;
        gap_d    = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q       <= ST_IDLE;
      credit_q      <= 3'd0;
      gap_q         <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      gap_q         <= gap_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Moore output decode from registered state.
  always_comb begin
    guffin         = (state_q == ST_VEND);
    quarter_out    = (state_q == ST_EJECT_Q);
    halfDollar_out = (state_q == ST_EJECT_H);
    busy           = (state_q != ST_IDLE);
    credit         = credit_q;
    state_code     = state_q;
    coin_reject    = coin_reject_q;
  end

endmodule
